pll_sweep_ctrl: RTL

//  Parametrised PLL frequency-sweep sequencer for memory test cores. Owns the entry index, replays an
//  8-write Avalon-MM reconfig burst into pll_cfg, pulses pll_reset and waits for relock.

---
 rtl/pll_sweep_pkg.sv | 41 ++++
 rtl/bcd_min_timer.sv | 57 +++++
 rtl/pll_sweep_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_sweep_pkg.sv
// Shared types and constants for the PLL frequency-sweep sequencer.
// The optional elapsed-time feature is enabled with the PLL_SWEEP_TIMER_EN macro.
package pll_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_GAP  = 3'd2,
    ST_RST  = 3'd3,
    ST_LOCK = 3'd4
  } state_t;

  // pll_cfg reconfig register addresses
  localparam logic [5:0] REG_MODE  = 6'd0;
  localparam logic [5:0] REG_M     = 6'd4;
  localparam logic [5:0] REG_K     = 6'd7;
  localparam logic [5:0] REG_N     = 6'd3;
  localparam logic [5:0] REG_C     = 6'd5;
  localparam logic [5:0] REG_CP    = 6'd9;
  localparam logic [5:0] REG_BW    = 6'd8;
  localparam logic [5:0] REG_START = 6'd2;

  localparam logic [31:0] N_VALUE  = 32'h0001_0000;
  localparam logic [31:0] CP_VALUE = 32'd1;
  localparam logic [31:0] BW_VALUE = 32'd7;

  // Address of each step of the 8-write reconfig burst
  function automatic logic [5:0] wr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return REG_MODE;
      3'd1:    return REG_M;
      3'd2:    return REG_K;
      3'd3:    return REG_N;
      3'd4:    return REG_C;
      3'd5:    return REG_CP;
      3'd6:    return REG_BW;
      default: return REG_START;
    endcase
  endfunction

endpackage

// File: rtl/bcd_min_timer.sv
// Minutes-since-relock counter: divides clk down to one tick per minute and
// counts ticks as 4 BCD digits (9999 wraps to 0000). Held at zero while clr.
// Built only when PLL_SWEEP_TIMER_EN is defined.
`ifdef PLL_SWEEP_TIMER_EN
module bcd_min_timer
  import pll_sweep_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  output logic [15:0] bcd
);

  localparam longint unsigned TICK_CYC = 64'd60 * 64'(CLK_HZ);
  localparam int              DW       = $clog2(TICK_CYC);
  localparam logic [DW-1:0]   DIV_LOAD = DW'(TICK_CYC - 64'd1);

  logic [DW-1:0] div;
  logic [15:0]   bcd_inc;
  logic          carry;

  // Ripple a +1 through the four decimal digits
  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Minute divider (down-counter) and BCD register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= DIV_LOAD;
      bcd <= 16'h0000;
    end else if (clr) begin
      div <= DIV_LOAD;
      bcd <= 16'h0000;
    end else if (div == '0) begin
      div <= DIV_LOAD;
      bcd <= bcd_inc;
    end else begin
      div <= div - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pll_sweep_ctrl.sv
// PLL frequency-sweep sequencer: owns the table position, replays the 8-write
// reconfig burst into pll_cfg, pulses pll_reset and waits for relock.
// Optional minutes-since-relock timer enabled by defining PLL_SWEEP_TIMER_EN.
//
// state   | meaning
// IDLE    | locked (or timed out), waiting for a command or auto-advance
// WR      | write strobe to pll_cfg; first cycle after restart loads addr/data
// GAP     | idle spacing after an accepted write
// RST     | pll_reset asserted
// LOCK    | waiting for synchronised pll_locked or timeout
module pll_sweep_ctrl
  import pll_sweep_pkg::*;
#(
  parameter int ENTRIES     = 38,
  parameter int GAP_CYC     = 8,
  parameter int RST_CYC     = 8,
  parameter int LOCK_TO_CYC = 50000000,
  parameter int CLK_HZ      = 50000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_up,
  input  logic                       cmd_dn,
  input  logic                       cmd_retry,
  input  logic                       cmd_auto,
  input  logic                       test_ok,
  input  logic [31:0]                tbl_m,
  input  logic [31:0]                tbl_k,
  input  logic [31:0]                tbl_c,
  output logic [$clog2(ENTRIES)-1:0] tbl_idx,
  output logic [5:0]                 mgmt_address,
  output logic [31:0]                mgmt_writedata,
  output logic                       mgmt_write,
  input  logic                       mgmt_waitrequest,
  input  logic                       pll_locked,
  output logic                       pll_reset,
  output logic                       busy,
  output logic                       auto_mode,
  output logic                       lock_err,
  output logic [15:0]                elapsed_bcd
);

  localparam int            PW      = $clog2(ENTRIES);
  localparam logic [PW-1:0] POS_MAX = PW'(ENTRIES - 1);

  state_t        state;
  logic [2:0]    idx;
  logic [31:0]   cnt;
  logic [PW-1:0] pos;
  logic          lock_s1, lock_s2;
  logic          cmd_acc;
  logic [PW-1:0] pos_nxt;
  logic          auto_nxt;
  logic [2:0]    wr_sel;
  logic [31:0]   wr_data;

  assign tbl_idx = pos;

  // Two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  // Pick at most one command per cycle; out-of-range up/dn are dropped outright
  always_comb begin
    cmd_acc  = 1'b0;
    pos_nxt  = pos;
    auto_nxt = auto_mode;
    if (cmd_auto) begin
      cmd_acc  = 1'b1;
      pos_nxt  = '0;
      auto_nxt = 1'b1;
    end else if (cmd_retry) begin
      cmd_acc  = 1'b1;
      auto_nxt = 1'b0;
    end else if (cmd_up) begin
      if (pos < POS_MAX) begin
        cmd_acc  = 1'b1;
        pos_nxt  = pos + 1'b1;
        auto_nxt = 1'b0;
      end
    end else if (cmd_dn) begin
      if (pos != '0) begin
        cmd_acc  = 1'b1;
        pos_nxt  = pos - 1'b1;
        auto_nxt = 1'b0;
      end
    end else if (auto_mode && test_ok && !busy && pos < POS_MAX) begin
      cmd_acc = 1'b1;
      pos_nxt = pos + 1'b1;
    end
  end

  // GAP preloads the following write, so look one step ahead there
  assign wr_sel = (state == ST_GAP) ? idx + 3'd1 : idx;

  // Data word for the selected burst step
  always_comb begin
    case (wr_sel)
      3'd1:    wr_data = tbl_m;
      3'd2:    wr_data = tbl_k;
      3'd3:    wr_data = N_VALUE;
      3'd4:    wr_data = tbl_c;
      3'd5:    wr_data = CP_VALUE;
      3'd6:    wr_data = BW_VALUE;
      default: wr_data = 32'h0;
    endcase
  end

  // Sequencer FSM; an accepted command aborts everything and restarts at write 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_WR;
      idx            <= 3'd0;
      cnt            <= 32'd0;
      pos            <= '0;
      auto_mode      <= 1'b0;
      busy           <= 1'b1;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      mgmt_write     <= 1'b0;
      pll_reset      <= 1'b0;
      lock_err       <= 1'b0;
    end else if (cmd_acc) begin
      pos        <= pos_nxt;
      auto_mode  <= auto_nxt;
      busy       <= 1'b1;
      lock_err   <= 1'b0;
      state      <= ST_WR;
      idx        <= 3'd0;
      mgmt_write <= 1'b0;
      pll_reset  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WR: begin
          if (!mgmt_write) begin
            mgmt_address   <= wr_addr(wr_sel);
            mgmt_writedata <= wr_data;
            mgmt_write     <= 1'b1;
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            state      <= ST_GAP;
            cnt        <= 32'(GAP_CYC - 1);
          end
        end
        ST_GAP: begin
          if (cnt == 32'd0) begin
            if (idx == 3'd7) begin
              pll_reset <= 1'b1;
              state     <= ST_RST;
              cnt       <= 32'(RST_CYC - 1);
            end else begin
              idx            <= wr_sel;
              mgmt_address   <= wr_addr(wr_sel);
              mgmt_writedata <= wr_data;
              mgmt_write     <= 1'b1;
              state          <= ST_WR;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ST_RST: begin
          if (cnt == 32'd0) begin
            pll_reset <= 1'b0;
            state     <= ST_LOCK;
            cnt       <= 32'(LOCK_TO_CYC - 1);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ST_LOCK: begin
          if (lock_s2) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == 32'd0) begin
            busy     <= 1'b0;
            lock_err <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PLL_SWEEP_TIMER_EN
  bcd_min_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (busy),
    .bcd   (elapsed_bcd)
  );
`else
  // CLK_HZ only matters to the timer
  logic unused_clk_hz;
  assign unused_clk_hz = ^32'(CLK_HZ);
  assign elapsed_bcd   = 16'h0000;
`endif

endmodule
